// File: rtl/minmax_pkg.sv
// Shared constants for the min/max scan controller: default sizes and
// FSM state encoding.
package minmax_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 3;
  localparam int NUM_REGS_DEF  = 8;
  localparam int NUM_PAIRS_DEF = NUM_REGS_DEF / 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/minmax_pair_cmp.sv
// Combinational two-input comparator returning the greater and lesser value.
// On equal inputs hi takes a and lo takes b.
// Define MINMAX_SIGNED_EN to compare as two's-complement signed; otherwise
// the comparison is unsigned.
module minmax_pair_cmp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic a_ge_b;

`ifdef MINMAX_SIGNED_EN
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  assign a_s    = a;
  assign b_s    = b;
  assign a_ge_b = (a_s >= b_s);
`else
  assign a_ge_b = (a >= b);
`endif

  // Route the larger operand to hi and the other to lo
  always_comb begin
    hi = b;
    lo = a;
    if (a_ge_b) begin
      hi = a;
      lo = b;
    end
  end

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Min/max scan controller sharing a dual-read register file with an
// external write port. A start request walks even/odd address pairs, one
// pair per cycle, accumulating the running maximum and minimum, then raises
// valid. External writes are held off while a scan is running.
// Compare signedness is chosen by the MINMAX_SIGNED_EN macro inside
// minmax_pair_cmp.
module minmax_scan_ctrl
  import minmax_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              start,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr_even,
  output logic [ADDR_W-1:0] rf_raddr_odd,
  input  logic [DATA_W-1:0] rf_rdata_even,
  input  logic [DATA_W-1:0] rf_rdata_odd,
  output logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] min,
  output logic              valid
);

  localparam int NUM_PAIRS = NUM_REGS / 2;
  localparam int PW        = ADDR_W - 1;
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PAIRS - 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic              valid_q, valid_d;

  logic              scan_act;
  logic              start_acc;
  logic [DATA_W-1:0] pair_hi, pair_lo;
  logic [DATA_W-1:0] max_new, min_new;
  logic [DATA_W-1:0] max_lo_unused, min_hi_unused;

  assign scan_act  = (state_q == ST_SCAN);
  assign wr_ready  = !scan_act;
  assign rf_we     = wr_req & wr_ready;
  assign rf_waddr  = wr_addr;
  assign rf_wdata  = wr_data;
  // A pending write wins over a simultaneous start
  assign start_acc = !scan_act && start && !wr_req;

  assign rf_raddr_even = scan_act ? {p_q, 1'b0} : ADDR_W'(0);
  assign rf_raddr_odd  = scan_act ? {p_q, 1'b1} : ADDR_W'(1);

  assign busy  = scan_act;
  assign max   = max_q;
  assign min   = min_q;
  assign valid = valid_q;

  minmax_pair_cmp #(.DATA_W(DATA_W)) u_pair_cmp (
    .a  (rf_rdata_even),
    .b  (rf_rdata_odd),
    .hi (pair_hi),
    .lo (pair_lo)
  );

  minmax_pair_cmp #(.DATA_W(DATA_W)) u_max_cmp (
    .a  (max_q),
    .b  (pair_hi),
    .hi (max_new),
    .lo (max_lo_unused)
  );

  minmax_pair_cmp #(.DATA_W(DATA_W)) u_min_cmp (
    .a  (min_q),
    .b  (pair_lo),
    .hi (min_hi_unused),
    .lo (min_new)
  );

  // Next-state, pair counter and accumulator update
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    max_d   = max_q;
    min_d   = min_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          valid_d = 1'b0;
          p_d     = '0;
          state_d = ST_SCAN;
        end else if (rf_we) begin
          // Register contents changed under the held result
          valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (p_q == '0) begin
          max_d = pair_hi;
          min_d = pair_lo;
        end else begin
          max_d = max_new;
          min_d = min_new;
        end
        p_d = p_q + 1'b1;
        if (p_q == P_LAST) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      max_q   <= '0;
      min_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      max_q   <= max_d;
      min_q   <= min_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Bench for minmax_scan_ctrl: table-driven vectors, hand-written corner
// sequences and randomized scans against a whole-array max/min model.
// Honours MINMAX_SIGNED_EN for its expectations.
module tb_minmax_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        start;
  logic        busy;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  rf_raddr_even;
  logic [2:0]  rf_raddr_odd;
  logic [15:0] rf_rdata_even;
  logic [15:0] rf_rdata_odd;
  logic [15:0] max;
  logic [15:0] min;
  logic        valid;

  int tests;
  int failed;

  // Register file driven by the DUT's write port; combinational reads
  logic [15:0] rf_mem [8];
  // Contents the bench believes are in the register file
  logic [15:0] exp_mem [8];

  assign rf_rdata_even = rf_mem[rf_raddr_even];
  assign rf_rdata_odd  = rf_mem[rf_raddr_odd];

  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  end

  minmax_scan_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .start         (start),
    .busy          (busy),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_raddr_even (rf_raddr_even),
    .rf_raddr_odd  (rf_raddr_odd),
    .rf_rdata_even (rf_rdata_even),
    .rf_rdata_odd  (rf_rdata_odd),
    .max           (max),
    .min           (min),
    .valid         (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [127:0] d;     // register i lives in d[16*i +: 16]
    logic [15:0]  mx_u;
    logic [15:0]  mn_u;
    logic [15:0]  mx_s;
    logic [15:0]  mn_s;
  } vec_t;

  vec_t tv [5];

  function automatic logic gt(input logic [15:0] a, input logic [15:0] b);
`ifdef MINMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [15:0] model_max();
    logic [15:0] m;
    m = exp_mem[0];
    for (int i = 1; i < 8; i++) if (gt(exp_mem[i], m)) m = exp_mem[i];
    return m;
  endfunction

  function automatic logic [15:0] model_min();
    logic [15:0] m;
    m = exp_mem[0];
    for (int i = 1; i < 8; i++) if (gt(m, exp_mem[i])) m = exp_mem[i];
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    int n;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    #1;
    n = 0;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    if (!wr_ready) chk("wr_ready_timeout", 32'(wr_ready), 32'd1);
    step();
    exp_mem[a] = d;
    wr_req = 1'b0;
  endtask

  // Request a scan (accepted at the next edge), check the busy window and
  // read addresses, then the result on the first DONE cycle
  task automatic scan_check(input string nm, input logic [15:0] emx, input logic [15:0] emn);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_valid_lo"}, 32'(valid), 32'd0);
      chk({nm, "_raddr_even"}, 32'(rf_raddr_even), 32'(2 * i));
      chk({nm, "_raddr_odd"}, 32'(rf_raddr_odd), 32'(2 * i + 1));
      step();
    end
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    chk({nm, "_valid"}, 32'(valid), 32'd1);
    chk({nm, "_max"}, 32'(max), 32'(emx));
    chk({nm, "_min"}, 32'(min), 32'(emn));
  endtask

  initial begin
    logic [15:0] hold_mx, hold_mn;
    tests   = 0;
    failed  = 0;
    rst     = 1'b1;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;

    tv[0].d = {16'd8, 16'd42, 16'd0, 16'd65535, 16'd17, 16'd3, 16'd900, 16'd5};
    tv[0].mx_u = 16'd65535; tv[0].mn_u = 16'd0;
    tv[0].mx_s = 16'd900;   tv[0].mn_s = 16'hFFFF;
    tv[1].d = {8{16'h1234}};
    tv[1].mx_u = 16'h1234;  tv[1].mn_u = 16'h1234;
    tv[1].mx_s = 16'h1234;  tv[1].mn_s = 16'h1234;
    tv[2].d = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'h7FFF, 16'h8000};
    tv[2].mx_u = 16'h8000;  tv[2].mn_u = 16'd1;
    tv[2].mx_s = 16'h7FFF;  tv[2].mn_s = 16'h8000;
    tv[3].d = {16'd9, {7{16'd10}}};
    tv[3].mx_u = 16'd10;    tv[3].mn_u = 16'd9;
    tv[3].mx_s = 16'd10;    tv[3].mn_s = 16'd9;
    tv[4].d = {16'hFFFF, {7{16'd0}}};
    tv[4].mx_u = 16'hFFFF;  tv[4].mn_u = 16'd0;
    tv[4].mx_s = 16'd0;     tv[4].mn_s = 16'hFFFF;

    // Reset state
    step(); step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_max", 32'(max), 32'd0);
    chk("rst_min", 32'(min), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_raddr_even", 32'(rf_raddr_even), 32'd0);
    chk("rst_raddr_odd", 32'(rf_raddr_odd), 32'd1);
    rst = 1'b0;
    step();

    // Table-driven vectors
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) do_write(3'(i), tv[k].d[16*i +: 16]);
`ifdef MINMAX_SIGNED_EN
      scan_check($sformatf("vec%0d", k), tv[k].mx_s, tv[k].mn_s);
`else
      scan_check($sformatf("vec%0d", k), tv[k].mx_u, tv[k].mn_u);
`endif
    end

    // Write held across a scan, plus an ignored start mid-scan
    hold_mx = model_max();
    hold_mn = model_min();
    start = 1'b1;
    step();
    start   = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 3'd2;
    wr_data = 16'd7;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_wr_ready", 32'(wr_ready), 32'd0);
      chk("stall_rf_we", 32'(rf_we), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_raddr_even", 32'(rf_raddr_even), 32'(2 * i));
      start = (i == 1);
      step();
    end
    chk("stall_done_wr_ready", 32'(wr_ready), 32'd1);
    chk("stall_done_rf_we", 32'(rf_we), 32'd1);
    chk("stall_done_valid", 32'(valid), 32'd1);
    chk("stall_done_max", 32'(max), 32'(hold_mx));
    chk("stall_done_min", 32'(min), 32'(hold_mn));
    step();
    wr_req = 1'b0;
    exp_mem[2] = 16'd7;
    chk("stale_valid", 32'(valid), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    chk("stale_max", 32'(max), 32'(hold_mx));
    chk("stale_min", 32'(min), 32'(hold_mn));
    chk("stale_rf2", 32'(rf_mem[2]), 32'd7);

    // Simultaneous start and write: write first, scan sees the new value
    start   = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 3'd7;
    wr_data = 16'd3;
    #1;
    chk("prio_rf_we", 32'(rf_we), 32'd1);
    step();
    exp_mem[7] = 16'd3;
    wr_req = 1'b0;
    chk("prio_not_started", 32'(busy), 32'd0);
    scan_check("prio", model_max(), model_min());

    // Reset in the second scan cycle, then a clean rescan
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_max", 32'(max), 32'd0);
    chk("midrst_min", 32'(min), 32'd0);
    chk("midrst_raddr_even", 32'(rf_raddr_even), 32'd0);
    scan_check("after_rst", model_max(), model_min());

    // Randomized register contents
    for (int r = 0; r < 15; r++) begin
      int nw;
      nw = $urandom_range(1, 8);
      for (int j = 0; j < nw; j++) begin
        logic [15:0] d;
        case ($urandom_range(0, 3))
          0: d = 16'h0000;
          1: d = 16'hFFFF;
          2: d = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
          default: d = 16'($urandom);
        endcase
        do_write(3'($urandom_range(0, 7)), d);
      end
      scan_check($sformatf("rand%0d", r), model_max(), model_min());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
